// File: rtl/command_dispatcher_pkg.sv
// Shared command definitions for the parser, dispatcher and controller interface.
package command_dispatcher_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [3:0] {
        G00, G01, G20, G21, G90, G91, M2, M6, M72
    } cmd_code_e;

    typedef struct packed {
        cmd_code_e   code;
        logic [15:0] x;
        logic [15:0] y;
    } command_t;

    function automatic logic is_program_end(input command_t c);
        return c.code == M2;
    endfunction

endpackage

// File: rtl/command_dispatcher_fifo.sv
// Circular command buffer with synchronous flush; pointers wrap modulo DEPTH.
module command_fifo
    import command_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  command_t                 din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output command_t                 head
);
    localparam int unsigned AW = $clog2(DEPTH);

    command_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/command_dispatcher.sv
// Buffers parsed commands and hands them to the controller one per handshake,
// with a one-cycle gap between transfers; stops at M2 until restart.
module command_dispatcher
    import command_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  command_t                 wr_cmd,
    output logic                     wr_ready,
    output command_t                 command_out,
    output logic                     memory_ready,
    input  logic                     controller_ready,
    input  logic                     restart,
    output logic                     program_done,
    output logic [$clog2(DEPTH):0]   count
);
    typedef enum logic [1:0] {IDLE, PRESENT, GAP, DONE} state_e;

    state_e    r_state;
    logic      r_memory_ready;
    logic      r_program_done;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_head_end;
    logic      w_transfer;
    command_t  w_head;

    assign w_head_end = !w_empty && is_program_end(w_head);
    assign w_transfer = (r_state == PRESENT) && controller_ready;
    // M2 is dropped from the buffer on the edge that enters DONE.
    assign w_pop      = !restart &&
                        (w_transfer || (((r_state == IDLE) || (r_state == GAP)) && w_head_end));
    assign wr_ready   = !w_full && (r_state != DONE);
    assign w_push     = wr_valid && wr_ready && !restart;

    assign command_out  = w_head;
    assign memory_ready = r_memory_ready;
    assign program_done = r_program_done;

    command_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (restart),
        .din   (wr_cmd),
        .full  (w_full),
        .empty (w_empty),
        .count (count),
        .head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_state        <= IDLE;
            r_memory_ready <= 1'b0;
            r_program_done <= 1'b0;
        end else begin
            case (r_state)
                // GAP makes the IDLE decision itself so a queued command is
                // re-presented after exactly one low cycle (1 per 2 cycles).
                IDLE, GAP: begin
                    if (w_head_end) begin
                        r_state        <= DONE;
                        r_memory_ready <= 1'b0;
                        r_program_done <= 1'b1;
                    end else if (!w_empty) begin
                        r_state        <= PRESENT;
                        r_memory_ready <= 1'b1;
                    end else begin
                        r_state        <= IDLE;
                        r_memory_ready <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (controller_ready) begin
                        r_state        <= GAP;
                        r_memory_ready <= 1'b0;
                    end
                end
                DONE: begin
                    r_state        <= DONE;
                    r_memory_ready <= 1'b0;
                    r_program_done <= 1'b1;
                end
                default: begin
                    r_state        <= IDLE;
                    r_memory_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_dispatcher.sv
// Scoreboard bench: writers queue expected deliveries, a monitor checks each handshake.
module tb_command_dispatcher;
    import command_dispatcher_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    command_t   wr_cmd;
    logic       wr_ready;
    command_t   command_out;
    logic       memory_ready;
    logic       controller_ready;
    logic       restart;
    logic       program_done;
    logic [3:0] count;

    command_t   sb[$];
    command_t   mon_exp;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pat;
    cmd_code_e  t1_codes [3] = '{G90, G01, G00};
    cmd_code_e  t2_codes [8] = '{G00, G01, G20, G21, G90, G91, M6, M72};

    always #5 clk = ~clk;

    command_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_cmd           (wr_cmd),
        .wr_ready         (wr_ready),
        .command_out      (command_out),
        .memory_ready     (memory_ready),
        .controller_ready (controller_ready),
        .restart          (restart),
        .program_done     (program_done),
        .count            (count)
    );

    function automatic command_t mk(input cmd_code_e c, input logic [15:0] v);
        command_t r;
        r.code = c;
        r.x    = v;
        r.y    = ~v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input cmd_code_e c, input logic [15:0] v, input bit fwd);
        wr_valid = 1'b1;
        wr_cmd   = mk(c, v);
        if (fwd) sb.push_back(wr_cmd);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (count != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(count), 32'd0);
    endtask

    // Monitor: every handshake must deliver the oldest expected command.
    always @(negedge clk) begin
        if (!reset && !restart && memory_ready) begin
            check("m2_not_presented", 32'(command_out.code == M2), 32'd0);
            if (controller_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", command_out);
                end else begin
                    mon_exp = sb.pop_front();
                    if (command_out !== mon_exp) begin
                        n_fail++;
                        $display("FAIL delivery_order: got %h expected %h", command_out, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        wr_valid         = 1'b0;
        wr_cmd           = '0;
        controller_ready = 1'b0;
        restart          = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_count",        32'(count),        32'd0);
        check("reset_memory_ready", 32'(memory_ready), 32'd0);
        check("reset_program_done", 32'(program_done), 32'd0);
        check("reset_wr_ready",     32'(wr_ready),     32'd1);

        // Three writes with the controller always ready.
        tick();
        controller_ready = 1'b1;
        wr_valid = 1'b1;
        wr_cmd   = mk(t1_codes[0], 16'h0010);
        sb.push_back(wr_cmd);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = memory_ready;
            tick();
            if (i + 1 < 3) begin
                wr_cmd = mk(t1_codes[i+1], 16'(16'h0010 + i + 1));
                sb.push_back(wr_cmd);
            end else begin
                wr_valid = 1'b0;
            end
        end
        check("t1_mready_pattern", 32'(pat), 32'h54);
        @(negedge clk);
        check("t1_count_zero", 32'(count), 32'd0);
        check("t1_sb_empty",   32'(sb.size()), 32'd0);

        // Fill to DEPTH with the controller stalled; the 9th write is dropped.
        tick();
        controller_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(t2_codes[i], 16'(16'h0100 + i), 1'b1);
        @(negedge clk);
        check("t2_count_full",    32'(count),        32'd8);
        check("t2_wr_ready_low",  32'(wr_ready),     32'd0);
        check("t2_memory_ready",  32'(memory_ready), 32'd1);
        tick();
        wr(M72, 16'hdead, 1'b0);
        @(negedge clk);
        check("t2_ninth_ignored", 32'(count), 32'd8);
        tick();
        controller_ready = 1'b1;
        wait_drain("t2_drain", 100);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // M2 ends the program; the command after it is held until restart.
        tick();
        tick();
        wr(G01, 16'h0201, 1'b1);
        wr(M2,  16'h0202, 1'b0);
        wr(G00, 16'h0203, 1'b0);
        for (int n = 0; n < 20 && !program_done; n++) @(negedge clk);
        @(negedge clk);
        check("t3_program_done", 32'(program_done), 32'd1);
        check("t3_count_held",   32'(count),        32'd1);
        check("t3_wr_ready_low", 32'(wr_ready),     32'd0);
        check("t3_mready_low",   32'(memory_ready), 32'd0);
        tick();
        wr(G21, 16'h0204, 1'b0);
        @(negedge clk);
        check("t3_write_in_done", 32'(count), 32'd1);
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        check("t3_restart_count", 32'(count),        32'd0);
        check("t3_restart_done",  32'(program_done), 32'd0);
        check("t3_restart_wrrdy", 32'(wr_ready),     32'd1);

        // Restart flushes the buffer and discards a simultaneous write.
        tick();
        controller_ready = 1'b0;
        wr(G20, 16'h0301, 1'b0);
        restart  = 1'b1;
        wr_valid = 1'b1;
        wr_cmd   = mk(G21, 16'h0302);
        tick();
        restart  = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check("t3b_flush_count", 32'(count),        32'd0);
        check("t3b_flush_mrdy",  32'(memory_ready), 32'd0);

        // Push and transfer on the same edge with three buffered.
        tick();
        wr(G00, 16'h0401, 1'b1);
        wr(G01, 16'h0402, 1'b1);
        wr(G90, 16'h0403, 1'b1);
        controller_ready = 1'b1;
        wr(G91, 16'h0404, 1'b1);
        controller_ready = 1'b0;
        @(negedge clk);
        check("t4_count_same", 32'(count), 32'd3);
        tick();
        controller_ready = 1'b1;
        wait_drain("t4_drain", 100);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while presenting wins over a pending transfer.
        tick();
        tick();
        controller_ready = 1'b0;
        wr(G00, 16'h0501, 1'b0);
        wr(G01, 16'h0502, 1'b0);
        @(negedge clk);
        check("t5_present_mrdy",  32'(memory_ready), 32'd1);
        check("t5_present_count", 32'(count),        32'd2);
        tick();
        reset            = 1'b1;
        controller_ready = 1'b1;
        tick();
        reset            = 1'b0;
        controller_ready = 1'b0;
        @(negedge clk);
        check("t5_reset_mrdy",  32'(memory_ready), 32'd0);
        check("t5_reset_count", 32'(count),        32'd0);
        check("t5_reset_done",  32'(program_done), 32'd0);
        check("t5_reset_wrrdy", 32'(wr_ready),     32'd1);
        check("final_sb_empty", 32'(sb.size()),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
